// File: rtl/hex_display_sequencer_pkg.sv
// Shared display code constants, sequencer state encoding and the code-building helpers.
// The downstream seven-segment encoders decode the same code space.
package hex_display_sequencer_pkg;

  localparam logic [3:0] Digit0   = 4'h0;
  localparam logic [3:0] Digit1   = 4'h1;
  localparam logic [3:0] Digit2   = 4'h2;
  localparam logic [3:0] Digit3   = 4'h4;
  localparam logic [3:0] Digit4   = 4'h8;
  localparam logic [3:0] CharE    = 4'hC;
  localparam logic [3:0] CharLowR = 4'hD;
  localparam logic [3:0] CharLowO = 4'hE;
  localparam logic [3:0] Blank    = 4'hF;
  localparam logic [3:0] Dash     = 4'h3;

  localparam logic [2:0] MaxLevel = 3'd4;

  typedef enum logic [1:0] {StIdle, StShow, StError} state_e;

  // Index 0 is HEX0 (rightmost digit).
  typedef logic [5:0][3:0] hex_word_t;

  function automatic logic [3:0] level_to_code(input logic [2:0] lvl);
    logic [3:0] code;
    case (lvl)
      3'd0:    code = Digit0;
      3'd1:    code = Digit1;
      3'd2:    code = Digit2;
      3'd3:    code = Digit3;
      3'd4:    code = Digit4;
      default: code = Dash;
    endcase
    return code;
  endfunction

  function automatic hex_word_t display_word(input state_e st, input logic phase_on,
                                             input logic [2:0] lvl);
    hex_word_t w;
    w = {6{Blank}};
    case (st)
      StIdle: w = {6{Dash}};
      StShow: w[0] = level_to_code(lvl);
      StError: begin
        if (phase_on) w = {CharE, CharLowR, CharLowR, CharLowO, CharLowR, Blank};
      end
      default: w = {6{Dash}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hex_display_sequencer_if.sv
// Strobe inputs and registered display outputs of the HEX5..HEX0 sequencer.
interface hex_display_sequencer_if;
  logic [2:0] level;
  logic       level_valid;
  logic       error;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] hex4;
  logic [3:0] hex5;
  logic       error_active;

  modport master (
    output level, level_valid, error,
    input  hex0, hex1, hex2, hex3, hex4, hex5, error_active
  );

  modport slave (
    input  level, level_valid, error,
    output hex0, hex1, hex2, hex3, hex4, hex5, error_active
  );
endinterface

// File: rtl/blink_tick_gen.sv
// Blink half-period counter: counts only while enabled and pulses tick on its terminal count.
module blink_tick_gen #(
  parameter int unsigned TICK_CYCLES = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || !enable_i || (cnt_q == CntMax)) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Latches a 0-4 level for display and flashes "Error" on error strobes, then restores the level.
module hex_display_sequencer
  import hex_display_sequencer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = 25000000,
  parameter int unsigned ERROR_FLASHES = 3
) (
  input logic                    clock,
  input logic                    reset,
  hex_display_sequencer_if.slave bus
);

  localparam int unsigned FlashW = ($clog2(2 * ERROR_FLASHES) < 1) ? 1 :
                                   $clog2(2 * ERROR_FLASHES);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(2 * ERROR_FLASHES - 1);

  state_e            state_q, state_d;
  logic              phase_on_q, phase_on_d;
  logic [FlashW-1:0] flash_q, flash_d;
  logic [2:0]        level_q, level_d;
  logic              have_q, have_d;
  hex_word_t         hex_q;
  logic              err_act_q;

  logic tick;
  logic err_req;
  logic lvl_ok;

  // An out-of-range level is treated as an error strobe.
  assign err_req = bus.error || (bus.level_valid && (bus.level > MaxLevel));
  assign lvl_ok  = bus.level_valid && (bus.level <= MaxLevel);

  blink_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .enable_i (state_q == StError),
    .restart_i(err_req),
    .tick_o   (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase_on_d = phase_on_q;
    flash_d    = flash_q;
    level_d    = level_q;
    have_d     = have_q;
    if (lvl_ok) begin
      level_d = bus.level;
      have_d  = 1'b1;
    end
    if (err_req) begin
      state_d    = StError;
      phase_on_d = 1'b1;
      flash_d    = '0;
    end else if (lvl_ok && (state_q != StError)) begin
      state_d = StShow;
    end else if ((state_q == StError) && tick) begin
      phase_on_d = ~phase_on_q;
      if (flash_q == FlashLast) begin
        flash_d = '0;
        state_d = have_d ? StShow : StIdle;
      end else begin
        flash_d = flash_q + 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state so they track the state with no extra lag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_on_q <= 1'b0;
      flash_q    <= '0;
      level_q    <= '0;
      have_q     <= 1'b0;
      hex_q      <= {6{Dash}};
      err_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_on_q <= phase_on_d;
      flash_q    <= flash_d;
      level_q    <= level_d;
      have_q     <= have_d;
      hex_q      <= display_word(state_d, phase_on_d, level_d);
      err_act_q  <= (state_d == StError);
    end
  end

  assign bus.hex0         = hex_q[0];
  assign bus.hex1         = hex_q[1];
  assign bus.hex2         = hex_q[2];
  assign bus.hex3         = hex_q[3];
  assign bus.hex4         = hex_q[4];
  assign bus.hex5         = hex_q[5];
  assign bus.error_active = err_act_q;

endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Upstream driver for six hex-to-seven-segment encoders on the DE1-SoC HEX5..HEX0 displays.
- Latches a game/status level (0-4) and shows it as a single digit.
- On an error event, flashes the word "Error" for a fixed number of blinks, then restores the level display.
- Every output is a 4-bit display code in the encoder's code space, not a raw digit.

Parameters:
- TICK_CYCLES, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); must be >=2
- ERROR_FLASHES, 3, number of on/off flash pairs in the error sequence; must be >=1

Ports:
- clock  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next clock edge)
- level  input  3  requested level value, sampled when level_valid==1
- level_valid  input  1  single-cycle strobe qualifying level
- error  input  1  single-cycle strobe requesting the error sequence
- hex0..hex5  output  4 each  display codes for HEX0 (rightmost) through HEX5; registered
- error_active  output  1  high while the error sequence is running; registered

Behaviour:
- Display code constants:
  - Digits: DIGIT_0=4'h0, DIGIT_1=4'h1, DIGIT_2=4'h2, DIGIT_3=4'h4, DIGIT_4=4'h8.
  - Letters: CHAR_E=4'hC, CHAR_r=4'hD, CHAR_o=4'hE.
  - Blank: BLANK=4'hF.
  - Dash: DASH=4'h3. Any unlisted code renders as "-"; the block always emits exactly 4'h3 for a dash.
- Level map: 0->4'h0, 1->4'h1, 2->4'h2, 3->4'h4, 4->4'h8. A level of 5-7 with level_valid==1 is treated exactly as an error strobe, and the stored level is unchanged.
- Reset:
  - state=IDLE, hex0..hex5=4'h3, error_active=0.
  - have_level=0, stored level=0, tick counter=0, flash counter=0.
  - Reset takes priority over every other input, including mid-sequence.
- States:
  - IDLE: all six outputs DASH.
  - SHOW: hex0=map(stored level), hex1..hex5=BLANK.
  - ERROR: error_active=1. During the ON phase hex5..hex1 = E,r,r,o,r (CHAR_E, CHAR_r, CHAR_r, CHAR_o, CHAR_r) and hex0=BLANK. During the OFF phase all six outputs are BLANK.
- Transitions, evaluated every cycle in priority order:
  1. An error strobe, or level_valid with level>4: enter ERROR from any state, including ERROR, which restarts the sequence. Phase=ON, tick counter=0, flash counter=0.
  2. level_valid with level<=4:
     - Store the level and set have_level=1.
     - From IDLE or SHOW, go to SHOW.
     - In ERROR, the level is stored but the display is unchanged.
  3. In ERROR on a tick:
     - Toggle phase and increment the flash counter.
     - When the flash counter reaches 2*ERROR_FLASHES-1 on a tick, exit to SHOW if have_level==1, else to IDLE. Set error_active=0 in the same update.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 only while in ERROR, and is held at 0 elsewhere.
  - A tick occurs in the cycle where the counter equals TICK_CYCLES-1; the counter then wraps to 0.
  - Each phase therefore lasts exactly TICK_CYCLES cycles.
  - Total ERROR dwell from entry to the exit update is 2*ERROR_FLASHES*TICK_CYCLES cycles.
- Latency: outputs reflect an input strobe exactly 1 cycle after the strobe edge (registered outputs, no combinational input-to-output path).
- Simultaneous error and valid level in the same cycle: the level is stored and ERROR is entered or restarted.
- Widths:
  - The tick counter is $clog2(TICK_CYCLES) bits.
  - The flash counter is $clog2(2*ERROR_FLASHES) bits, minimum 1.
  - No overflow is possible because both counters wrap or exit at their terminal value.

Decomposition:
- Shared package or include (display_codes) holds:
  - the code constants DIGIT_0..DIGIT_4, CHAR_E, CHAR_r, CHAR_o, BLANK, DASH
  - the state encoding IDLE/SHOW/ERROR
  - the level-to-code mapping function
- The seven-segment encoder consumes the same constants.
- One sub-module, blink_tick_gen:
  - Parameter TICK_CYCLES; inputs clock, reset, enable, restart; output tick.
  - Encapsulates the phase counter.
- The sequencer itself holds the FSM, the level register and the output registers.

Test Plan (TICK_CYCLES=4, ERROR_FLASHES=2):
- Reset held low 3 cycles, then released -> hex5..hex0 all 4'h3, error_active=0, both during and after reset.
- level=3 with level_valid pulse -> the next cycle shows hex0=4'h4 and hex1..hex5=4'hF, stable until the next event.
- error pulse after level=2 is shown:
  - Cycle+1: hex5..hex0 = C,D,D,E,D,F and error_active=1.
  - The ON/OFF pattern alternates every 4 cycles for 16 cycles.
  - After that, hex0=4'h2, all other outputs 4'hF, error_active=0.
- error pulse from reset with no level ever stored -> runs the 16-cycle sequence, then returns to all 4'h3.
- level=7 with level_valid, then 6 cycles later level=1 with level_valid, then a second error pulse at cycle 10:
  - level=7 starts ERROR.
  - level=1 during ERROR is stored silently.
  - The second error restarts the 16-cycle sequence.
  - On exit, hex0=4'h1.
- reset asserted mid-ERROR during the OFF phase -> the next cycle shows all 4'h3 and error_active=0; the stored level is cleared (a later error exits to IDLE).
